seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 140 ++++++++++++++
 tb/tb_seq_divider.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential 16-by-8 unsigned restoring divider, one quotient bit per clock.
// Results stay registered until a new request or an operand change is seen.
module seq_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic        done_flag,
  output logic        div_by_zero,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CALC = 3'd1,
    DONE = 3'd2,
    ERR  = 3'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] op_dividend_reg, op_dividend_next;
  logic [7:0]  op_divisor_reg, op_divisor_next;
  logic [8:0]  prem_reg, prem_next;
  logic [3:0]  count_reg, count_next;
  logic [14:0] qwork_reg, qwork_next;
  logic [15:0] quotient_reg, quotient_next;
  logic [7:0]  remainder_reg, remainder_next;
  logic        done_reg, done_next;
  logic        dbz_reg, dbz_next;

  logic        accept;
  logic        operands_changed;
  logic [9:0]  shifted;
  logic [8:0]  trial;
  logic        fits;
  logic [8:0]  step_prem;

  // Partial remainder is kept one bit wider than the divisor so the compare
  // never loses the carry-out when the divisor is 8'h80 or larger.
  assign shifted          = {prem_reg, op_dividend_reg[4'd15 - count_reg]};
  assign fits             = shifted >= {2'b00, op_divisor_reg};
  assign trial            = shifted[8:0] - {1'b0, op_divisor_reg};
  assign step_prem        = fits ? trial : shifted[8:0];
  assign operands_changed = (dividend != op_dividend_reg) || (divisor != op_divisor_reg);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      op_dividend_reg <= '0;
      op_divisor_reg  <= '0;
      prem_reg        <= '0;
      count_reg       <= '0;
      qwork_reg       <= '0;
      quotient_reg    <= '0;
      remainder_reg   <= '0;
      done_reg        <= 1'b0;
      dbz_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      op_dividend_reg <= op_dividend_next;
      op_divisor_reg  <= op_divisor_next;
      prem_reg        <= prem_next;
      count_reg       <= count_next;
      qwork_reg       <= qwork_next;
      quotient_reg    <= quotient_next;
      remainder_reg   <= remainder_next;
      done_reg        <= done_next;
      dbz_reg         <= dbz_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    op_dividend_next = op_dividend_reg;
    op_divisor_next  = op_divisor_reg;
    prem_next        = prem_reg;
    count_next       = count_reg;
    qwork_next       = qwork_reg;
    quotient_next    = quotient_reg;
    remainder_next   = remainder_reg;
    done_next        = done_reg;
    dbz_next         = dbz_reg;
    accept           = 1'b0;

    case (state_reg)
      IDLE: accept = start;
      CALC: begin
        prem_next  = step_prem;
        qwork_next = {qwork_reg[13:0], fits};
        count_next = count_reg + 4'd1;
        if (count_reg == 4'd15) begin
          quotient_next  = {qwork_reg, fits};
          remainder_next = step_prem[7:0];
          done_next      = 1'b1;
          dbz_next       = 1'b0;
          state_next     = DONE;
        end
      end
      DONE, ERR: begin
        if (start) begin
          accept = 1'b1;
        end else if (operands_changed) begin
          done_next  = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // A new request relatches operands from IDLE, DONE or ERR alike.
    if (accept) begin
      op_dividend_next = dividend;
      op_divisor_next  = divisor;
      prem_next        = '0;
      count_next       = '0;
      qwork_next       = '0;
      if (divisor == 8'd0) begin
        quotient_next  = 16'hFFFF;
        remainder_next = 8'hFF;
        done_next      = 1'b1;
        dbz_next       = 1'b1;
        state_next     = ERR;
      end else begin
        done_next  = 1'b0;
        dbz_next   = 1'b0;
        state_next = CALC;
      end
    end
  end

  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign done_flag   = done_reg;
  assign div_by_zero = dbz_reg;
  assign state       = state_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: fixed latency, boundary operands,
// divide-by-zero, mid-division reset, ignored inputs and restart from DONE.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        done_flag;
  logic        div_by_zero;
  logic [2:0]  state;

  int n_checks = 0;
  int n_fail   = 0;

  seq_divider dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .done_flag   (done_flag),
    .div_by_zero (div_by_zero),
    .state       (state)
  );

  initial forever #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Apply operands with start and take the sampling edge N.
  task automatic start_div(input logic [15:0] dvd, input logic [7:0] dvs);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    step();
    start = 1'b0;
    check_eq("start_state", {29'd0, state}, 32'd1);
    check_eq("start_done", {31'd0, done_flag}, 32'd0);
  endtask

  // Edges N+1..N+16: results must hold until the 16th step, then appear.
  task automatic finish_div(input string tag, input logic [15:0] exp_q, input logic [7:0] exp_r,
                            input logic [15:0] prev_q, input logic [7:0] prev_r, input int already);
    repeat (15 - already) step();
    check_eq({tag, "_n15_done"}, {31'd0, done_flag}, 32'd0);
    check_eq({tag, "_n15_q_hold"}, {16'd0, quotient}, {16'd0, prev_q});
    check_eq({tag, "_n15_r_hold"}, {24'd0, remainder}, {24'd0, prev_r});
    step();
    check_eq({tag, "_done"}, {31'd0, done_flag}, 32'd1);
    check_eq({tag, "_q"}, {16'd0, quotient}, {16'd0, exp_q});
    check_eq({tag, "_r"}, {24'd0, remainder}, {24'd0, exp_r});
    check_eq({tag, "_dbz"}, {31'd0, div_by_zero}, 32'd0);
    check_eq({tag, "_state"}, {29'd0, state}, 32'd2);
    $display("div %s: q=%0d r=%0d done=%0d state=%0d", tag, quotient, remainder, done_flag, state);
  endtask

  initial begin
    // Reset values while held in reset
    repeat (3) step();
    check_eq("rst_state", {29'd0, state}, 32'd0);
    check_eq("rst_q", {16'd0, quotient}, 32'd0);
    check_eq("rst_r", {24'd0, remainder}, 32'd0);
    check_eq("rst_done", {31'd0, done_flag}, 32'd0);
    check_eq("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    #3 rst = 1'b1;
    step();
    check_eq("post_rst_idle", {29'd0, state}, 32'd0);

    // Basic division, boundaries and restarts straight from DONE
    start_div(16'd1000, 8'd7);
    finish_div("1000/7", 16'd142, 8'd6, 16'd0, 8'd0, 0);
    start_div(16'd65535, 8'd255);
    finish_div("65535/255", 16'd257, 8'd0, 16'd142, 8'd6, 0);
    start_div(16'd5, 8'd9);
    finish_div("5/9", 16'd0, 8'd5, 16'd257, 8'd0, 0);
    start_div(16'd255, 8'd128);
    finish_div("255/128", 16'd1, 8'd127, 16'd0, 8'd5, 0);
    start_div(16'd300, 8'd20);
    finish_div("300/20", 16'd15, 8'd0, 16'd1, 8'd127, 0);

    // Divide by zero, then an operand change without start
    dividend = 16'd1234;
    divisor  = 8'd0;
    start    = 1'b1;
    step();
    start = 1'b0;
    check_eq("dz_state", {29'd0, state}, 32'd3);
    check_eq("dz_done", {31'd0, done_flag}, 32'd1);
    check_eq("dz_flag", {31'd0, div_by_zero}, 32'd1);
    check_eq("dz_q", {16'd0, quotient}, 32'h0000FFFF);
    check_eq("dz_r", {24'd0, remainder}, 32'h000000FF);
    step();
    check_eq("dz_hold_state", {29'd0, state}, 32'd3);
    divisor = 8'd3;
    step();
    check_eq("dz_chg_state", {29'd0, state}, 32'd0);
    check_eq("dz_chg_done", {31'd0, done_flag}, 32'd0);
    check_eq("dz_chg_q_hold", {16'd0, quotient}, 32'h0000FFFF);
    check_eq("dz_chg_flag_hold", {31'd0, div_by_zero}, 32'd1);
    $display("div 1234/0: state=%0d dbz=%0d", state, div_by_zero);

    // Asynchronous reset in the middle of CALC
    start_div(16'd1000, 8'd7);
    repeat (7) step();
    #2 rst = 1'b0;
    #1;
    check_eq("midrst_state", {29'd0, state}, 32'd0);
    check_eq("midrst_q", {16'd0, quotient}, 32'd0);
    check_eq("midrst_r", {24'd0, remainder}, 32'd0);
    check_eq("midrst_done", {31'd0, done_flag}, 32'd0);
    check_eq("midrst_dbz", {31'd0, div_by_zero}, 32'd0);
    step();
    #3 rst = 1'b1;
    repeat (3) step();
    check_eq("no_resume_state", {29'd0, state}, 32'd0);
    check_eq("no_resume_done", {31'd0, done_flag}, 32'd0);
    start_div(16'd100, 8'd10);
    finish_div("100/10", 16'd10, 8'd0, 16'd0, 8'd0, 0);

    // start and dividend changes during CALC are ignored
    start_div(16'd1000, 8'd7);
    repeat (4) step();
    start    = 1'b1;
    dividend = 16'd500;
    step();
    start = 1'b0;
    finish_div("1000/7_ign", 16'd142, 8'd6, 16'd10, 8'd0, 5);
    step();
    check_eq("chg_after_done_state", {29'd0, state}, 32'd0);
    check_eq("chg_after_done_flag", {31'd0, done_flag}, 32'd0);
    check_eq("chg_after_done_q", {16'd0, quotient}, 32'd142);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
